fp_pipe_cfg: RTL

- Parametrised, runtime-configurable filter pipeline over bit-vector lanes:
  - `LANES` lanes of `BIT_VEC_SIZE`-bit vectors pass through `STAGES` registered stages.
  - Each stage applies a lane crossbar, then a pairwise boolean filter op.
- Successor to the fixed-width filter pipeline. Adds valid/ready flow control, real valid propagation and per-stage configuration in double-buffered registers. Configuration changes commit atomically after the pipeline drains.
- Sits between the bit-vector producers and the result collector.

---
 rtl/fp_pkg.sv | 37 +++
 rtl/fp_stage.sv | 62 ++++++
 rtl/fp_pipe_cfg.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types for the configurable filter pipeline:
// stage config word layout, opcodes, config FSM states.
package fp_pkg;

   localparam int CFG_W = 40;

   localparam logic [2:0] FP_PASS  = 3'd0;
   localparam logic [2:0] FP_AND   = 3'd1;
   localparam logic [2:0] FP_OR    = 3'd2;
   localparam logic [2:0] FP_XOR   = 3'd3;
   localparam logic [2:0] FP_ANDN  = 3'd4;
   localparam logic [2:0] FP_SWAP  = 3'd5;
   localparam logic [2:0] FP_ZERO  = 3'd6;
   localparam logic [2:0] FP_PASS7 = 3'd7;

   // choice [39:36], op [35:24], sel [23:0]
   typedef struct packed {
      logic [3:0]      choice;
      logic [3:0][2:0] op;
      logic [7:0][2:0] sel;
   } fp_stage_cfg_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_SWAP
   } fp_cfg_state_e;

   // Identity: lane l reads lane l, all pairs PASS.
   function automatic fp_stage_cfg_t fp_ident_cfg();
      fp_stage_cfg_t c;
      c = '0;
      for (int l = 0; l < 8; l++) c.sel[l] = 3'(l);
      return c;
   endfunction

endpackage

// File: rtl/fp_stage.sv
// One combinational filter stage: lane crossbar, then pair ops.
// Ports: lanes_in, cfg (fp_stage_cfg_t) -> lanes_out.
module fp_stage
   import fp_pkg::*;
#(
   parameter int LANES        = 4,
   parameter int BIT_VEC_SIZE = 128
) (
   input  logic [LANES-1:0][BIT_VEC_SIZE-1:0] lanes_in,
   input  fp_stage_cfg_t                      cfg,
   output logic [LANES-1:0][BIT_VEC_SIZE-1:0] lanes_out
);

   logic [LANES-1:0][BIT_VEC_SIZE-1:0] xbar;
   logic [BIT_VEC_SIZE-1:0]            a;
   logic [BIT_VEC_SIZE-1:0]            b;
   logic [BIT_VEC_SIZE-1:0]            r;
   logic                               unused_cfg;

   // Entries beyond LANES / LANES/2 have no effect.
   assign unused_cfg = ^cfg;

   // A selector matching no lane leaves the lane zero.
   always_comb begin
      xbar = '0;
      for (int l = 0; l < LANES; l++)
         for (int k = 0; k < LANES; k++)
            if (cfg.sel[l] == 3'(k)) xbar[l] = lanes_in[k];
   end

   always_comb begin
      lanes_out = xbar;
      a = '0;
      b = '0;
      r = '0;
      for (int p = 0; p < LANES / 2; p++) begin
         a = xbar[2*p];
         b = xbar[2*p+1];
         case (cfg.op[p])
            FP_AND:  r = a & b;
            FP_OR:   r = a | b;
            FP_XOR:  r = a ^ b;
            FP_ANDN: r = a & ~b;
            FP_ZERO: r = '0;
            default: r = a;
         endcase
         case (cfg.op[p])
            FP_PASS, FP_PASS7: ;
            FP_SWAP: begin
               lanes_out[2*p]   = b;
               lanes_out[2*p+1] = a;
            end
            default: begin
               lanes_out[2*p] = r;
               // choice=1 lets lane b through untouched
               if (!cfg.choice[p]) lanes_out[2*p+1] = r;
            end
         endcase
      end
   end

endmodule

// File: rtl/fp_pipe_cfg.sv
// Filter pipeline with valid/ready flow control and
// double-buffered per-stage config committed after a drain.
// Ports: in_* / out_* beat handshakes, out_nz lane flags,
// cfg_* shadow writes and commit, beat_count of output beats.
module fp_pipe_cfg
   import fp_pkg::*;
#(
   parameter int LANES        = 4,
   parameter int STAGES       = 8,
   parameter int BIT_VEC_SIZE = 128,
   parameter int STAGE_LOG    = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [LANES-1:0][BIT_VEC_SIZE-1:0] in_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [LANES-1:0][BIT_VEC_SIZE-1:0] out_data,
   output logic [LANES-1:0]                   out_nz,
   output logic                               out_valid,
   input  logic                               out_ready,
   input  logic                               cfg_wr_en,
   input  logic [STAGE_LOG-1:0]               cfg_wr_stage,
   input  logic [CFG_W-1:0]                   cfg_wr_data,
   output logic                               cfg_ready,
   input  logic                               cfg_commit,
   output logic                               cfg_busy,
   output logic [31:0]                        beat_count
);

   typedef logic [LANES-1:0][BIT_VEC_SIZE-1:0] lanes_t;

   lanes_t          st_q [STAGES];
   lanes_t          st_d [STAGES];
   logic [STAGES-1:0] v_q;
   logic [LANES-1:0]  nz_q;
   logic [LANES-1:0]  nz_d;
   fp_stage_cfg_t   act_q [STAGES];
   fp_stage_cfg_t   shd_q [STAGES];
   fp_cfg_state_e   state_q;
   fp_cfg_state_e   state_d;
   logic            advance;
   logic            wr_ok;

   assign advance = !v_q[STAGES-1] | out_ready;
   assign wr_ok   = cfg_wr_en & (state_q == ST_IDLE);

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      lanes_t src;
      if (s == 0) begin : g_first
         assign src = in_data;
      end else begin : g_rest
         assign src = st_q[s-1];
      end
      fp_stage #(
         .LANES       (LANES),
         .BIT_VEC_SIZE(BIT_VEC_SIZE)
      ) u_stage (
         .lanes_in (src),
         .cfg      (act_q[s]),
         .lanes_out(st_d[s])
      );
   end

   // nz is registered with the last stage so out_nz
   // has no combinational path to the outputs.
   always_comb begin
      nz_d = '0;
      for (int l = 0; l < LANES; l++)
         nz_d[l] = |st_d[STAGES-1][l];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q  <= '0;
         nz_q <= '0;
         for (int s = 0; s < STAGES; s++) st_q[s] <= '0;
      end else if (advance) begin
         v_q  <= (v_q << 1) | STAGES'(in_valid & in_ready);
         nz_q <= nz_d;
         for (int s = 0; s < STAGES; s++) st_q[s] <= st_d[s];
      end
   end

   assign out_data  = st_q[STAGES-1];
   assign out_valid = v_q[STAGES-1];
   assign out_nz    = nz_q;

   // Stage indices with no matching s are dropped here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < STAGES; s++) begin
            act_q[s] <= fp_ident_cfg();
            shd_q[s] <= fp_ident_cfg();
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (wr_ok && cfg_wr_stage == STAGE_LOG'(s))
               shd_q[s] <= fp_stage_cfg_t'(cfg_wr_data);
            if (state_q == ST_SWAP)
               act_q[s] <= shd_q[s];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cfg_commit) state_d = ST_DRAIN;
         ST_DRAIN: if (v_q == '0)  state_d = ST_SWAP;
         ST_SWAP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready = (state_q == ST_IDLE);
      cfg_busy  = !cfg_ready;
      in_ready  = advance & cfg_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         beat_count <= '0;
      else if (out_valid && out_ready)
         beat_count <= beat_count + 32'd1;
   end

endmodule
